// File: rtl/cordic_scheduler.sv
// Shares one rectangular-to-polar CORDIC across all channels of a frame; results are gathered in order.
// Define CORDIC_SCHED_TIMEOUT_EN to enable the stall watchdog and its sticky timeout_out flag.
module cordic_scheduler #(
  parameter int CHANNELS       = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk_in,
  input  logic                           rst_in_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                           valid_in,
  output logic                           ready_out,
  output logic [DATA_WIDTH-1:0]          cordic_tdata,
  output logic                           cordic_tvalid,
  input  logic                           cordic_tready,
  input  logic [DATA_WIDTH-1:0]          cordic_dout_tdata,
  input  logic                           cordic_dout_tvalid,
  output logic [DATA_WIDTH-1:0]          data_out [CHANNELS-1:0],
  output logic                           valid_out,
  output logic                           timeout_out
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(CHANNELS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHANNELS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_ready;
  logic                  r_valid;
  logic [IDX_W-1:0]      r_issue_idx;
  logic [CNT_W-1:0]      r_result_cnt;
  logic [DATA_WIDTH-1:0] r_buf    [CHANNELS];
  logic [DATA_WIDTH-1:0] r_shadow [CHANNELS];

  logic w_accept;
  logic w_issue_hs;
  logic w_last_issue;
  logic w_capture;
  logic w_frame_done;
  logic w_abort;

  assign w_accept     = valid_in && r_ready && (r_state == S_IDLE);
  assign w_issue_hs   = (r_state == S_ISSUE) && cordic_tready;
  assign w_last_issue = w_issue_hs && (r_issue_idx == LAST_IDX);
  // Results outside ISSUE/DRAIN (stray or from a discarded frame) are dropped.
  assign w_capture    = cordic_dout_tvalid && (r_result_cnt < FULL_CNT) &&
                        ((r_state == S_ISSUE) || (r_state == S_DRAIN));
  assign w_frame_done = (r_result_cnt == FULL_CNT);

`ifdef CORDIC_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;
  logic            w_active;
  logic            w_event;

  assign w_active = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_event  = w_issue_hs || w_capture;
  // Abort on the edge that would complete TIMEOUT_CYCLES consecutive cycles without progress.
  assign w_abort  = w_active && !w_event && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_active || w_event) r_to_cnt <= '0;
      else                      r_to_cnt <= r_to_cnt + 1'b1;
      if (w_abort) r_timeout <= 1'b1;
    end
  end

  assign timeout_out = r_timeout;
`else
  assign w_abort     = 1'b0;
  assign timeout_out = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: begin
        if (w_abort)           w_next = S_IDLE;
        else if (w_frame_done) w_next = S_DONE;
        else if (w_last_issue) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_abort)           w_next = S_IDLE;
        else if (w_frame_done) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cordic_tvalid = (r_state == S_ISSUE);
    cordic_tdata  = r_buf[r_issue_idx];
  end

  // Registered outputs are loaded from the next state so they line up with the state they describe.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) data_out[k] <= '0;
    end else begin
      r_ready <= (w_next == S_IDLE);
      r_valid <= (w_next == S_DONE);
      if (w_next == S_DONE) begin
        for (int k = 0; k < CHANNELS; k++) data_out[k] <= r_shadow[k];
      end
    end
  end

  assign ready_out = r_ready;
  assign valid_out = r_valid;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_issue_idx  <= '0;
      r_result_cnt <= '0;
    end else if (w_accept) begin
      r_issue_idx  <= '0;
      r_result_cnt <= '0;
    end else begin
      if (w_issue_hs) r_issue_idx  <= r_issue_idx + 1'b1;
      if (w_capture)  r_result_cnt <= r_result_cnt + 1'b1;
    end
  end

  // Frame and shadow buffers are pure data and carry no reset.
  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      for (int k = 0; k < CHANNELS; k++) r_buf[k] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
    end
    if (w_capture) r_shadow[r_result_cnt[IDX_W-1:0]] <= cordic_dout_tdata;
  end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Randomized bench for cordic_scheduler with a latency-LAT CORDIC model and a frame-level reference.
module tb_cordic_scheduler;
  localparam int CH  = 4;
  localparam int DW  = 32;
  localparam int TO  = 16;
  localparam int LAT = 5;

  logic              clk_in = 1'b0;
  logic              rst_in_n;
  logic [CH*DW-1:0]  data_in;
  logic              valid_in;
  logic              ready_out;
  logic [DW-1:0]     cordic_tdata;
  logic              cordic_tvalid;
  logic              cordic_tready;
  logic [DW-1:0]     cordic_dout_tdata;
  logic              cordic_dout_tvalid;
  logic [DW-1:0]     data_out [CH-1:0];
  logic              valid_out;
  logic              timeout_out;

  always #5 clk_in = ~clk_in;

  cordic_scheduler #(.CHANNELS(CH), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .cordic_tdata(cordic_tdata), .cordic_tvalid(cordic_tvalid),
    .cordic_tready(cordic_tready), .cordic_dout_tdata(cordic_dout_tdata),
    .cordic_dout_tvalid(cordic_dout_tvalid), .data_out(data_out),
    .valid_out(valid_out), .timeout_out(timeout_out)
  );

  typedef struct { int due; logic [DW-1:0] d; } res_t;

  int total = 0;
  int bad   = 0;

  // reference state
  int            cyc = 0;
  bit            busy = 0;
  bit            to_exp = 0;
  int            v_exp = -1;
  int            issued = 0;
  int            idle = 0;
  int            res_num = 0;
  int            acc_cnt = 0;
  int            acc_cyc = 0;
  int            iss0_cyc = 0;
  int            v_seen = 0;
  logic [DW-1:0] cur_frame [CH];
  logic [DW-1:0] held      [CH];
  res_t          res_q [$];

  // stimulus controls
  bit               drv_valid = 0;
  logic [CH*DW-1:0] drv_data  = '0;
  int               tr_mode = 0;
  int               stall_left = 0;
  int               drop_idx = -1;
  bit               stray_req = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // CORDIC stand-in: any fixed bijection proves the result path is not the input path.
  function automatic logic [DW-1:0] cordic_ref(input logic [DW-1:0] x);
    return {x[15:0], x[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    bit   exp_rdy, exp_tv, ev;
    res_t r;
    @(negedge clk_in);
    cyc++;
    exp_rdy = !busy;
    if (busy && cyc == v_exp)
      for (int k = 0; k < CH; k++) held[k] = cordic_ref(cur_frame[k]);
    check_val("ready_out", ready_out, exp_rdy);
    check_val("valid_out", valid_out, busy && cyc == v_exp);
    if (valid_out) v_seen = cyc;
    for (int k = 0; k < CH; k++) check_val($sformatf("data_out%0d", k), data_out[k], held[k]);
    check_val("timeout_out", timeout_out, to_exp);
    exp_tv = busy && issued < CH;
    check_val("tvalid", cordic_tvalid, exp_tv);
    if (exp_tv) check_val($sformatf("tdata%0d", issued), cordic_tdata, cur_frame[issued]);

    cordic_tready = 1'b1;
    if (tr_mode == 1) cordic_tready = ($urandom_range(0, 3) != 0);
    if (tr_mode == 2 && exp_tv && issued == 2 && stall_left > 0) begin
      cordic_tready = 1'b0;
      stall_left--;
    end

    while (res_q.size() > 0 && res_q[0].due < cyc) void'(res_q.pop_front());
    cordic_dout_tvalid = 1'b0;
    cordic_dout_tdata  = $urandom;
    if (res_q.size() > 0 && res_q[0].due == cyc) begin
      r = res_q.pop_front();
      if (res_num != drop_idx) begin
        cordic_dout_tvalid = 1'b1;
        cordic_dout_tdata  = cordic_ref(r.d);
      end
      res_num++;
    end else if (stray_req) begin
      cordic_dout_tvalid = 1'b1;
      stray_req = 0;
    end
    valid_in = drv_valid;
    data_in  = drv_data;

    ev = 0;
    if (exp_tv && cordic_tready) begin
      if (issued == 0) iss0_cyc = cyc;
      r.due = cyc + LAT;
      r.d   = cur_frame[issued];
      res_q.push_back(r);
      issued++;
      ev = 1;
      if (issued == CH && drop_idx < 0) v_exp = cyc + LAT + 2;
    end
    if (cordic_dout_tvalid && busy && cyc != v_exp) ev = 1;
`ifdef CORDIC_SCHED_TIMEOUT_EN
    if (busy && cyc != v_exp) begin
      if (ev) idle = 0;
      else begin
        idle++;
        if (idle == TO) begin
          busy   = 0;
          to_exp = 1;
        end
      end
    end
`endif
    if (busy && cyc == v_exp) busy = 0;
    if (exp_rdy && drv_valid) begin
      busy = 1;
      for (int k = 0; k < CH; k++) cur_frame[k] = drv_data[k*DW +: DW];
      issued  = 0;
      idle    = 0;
      v_exp   = -1;
      res_num = 0;
      acc_cyc = cyc;
      acc_cnt++;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_in);
    cyc++;
    rst_in_n = 1'b0;
    drv_valid = 0;
    valid_in = 1'b0;
    cordic_dout_tvalid = 1'b0;
    cordic_tready = 1'b1;
    #1;
    check_val("rst_ready", ready_out, 1'b0);
    check_val("rst_valid", valid_out, 1'b0);
    check_val("rst_tvalid", cordic_tvalid, 1'b0);
    check_val("rst_timeout", timeout_out, 1'b0);
    for (int k = 0; k < CH; k++) check_val($sformatf("rst_data%0d", k), data_out[k], '0);
    repeat (n) begin
      @(negedge clk_in);
      cyc++;
    end
    rst_in_n = 1'b1;
    busy = 0; to_exp = 0; v_exp = -1; issued = 0; idle = 0;
    for (int k = 0; k < CH; k++) held[k] = '0;
  endtask

  task automatic send(input logic [CH*DW-1:0] frame);
    int a0 = acc_cnt;
    int n  = 0;
    drv_data  = frame;
    drv_valid = 1;
    while (acc_cnt == a0 && n < 200) begin
      tick();
      n++;
    end
    if (acc_cnt == a0) check_val("accept_wait", 0, 1);
    drv_valid = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) check_val("idle_wait", 0, 1);
  endtask

  function automatic logic [CH*DW-1:0] rand_frame();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int a1, a2, n;
    rst_in_n = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    cordic_tready = 1'b1;
    cordic_dout_tvalid = 1'b0;
    cordic_dout_tdata  = '0;
    do_reset(3);
    tick();

    // single frame, full-rate CORDIC
    send({32'h44, 32'h33, 32'h22, 32'h11});
    wait_idle(100);
    check_val("first_issue", iss0_cyc - acc_cyc, 1);
    check_val("lat_single", v_seen - acc_cyc, CH + LAT + 2);
    check_val("word3", data_out[3], cordic_ref(32'h44));
    check_val("word0", data_out[0], cordic_ref(32'h11));
    tick();

    // three stall cycles on channel 2
    tr_mode = 2;
    stall_left = 3;
    send({32'h88, 32'h33, 32'h66, 32'h55});
    wait_idle(100);
    check_val("lat_stall", v_seen - acc_cyc, CH + LAT + 2 + 3);
    tr_mode = 0;
    repeat (2) tick();

    // back-to-back with valid_in held
    drv_data = rand_frame();
    drv_valid = 1;
    n = 0;
    while (acc_cnt == 2 && n < 50) begin tick(); n++; end
    a1 = acc_cyc;
    drv_data = rand_frame();
    n = 0;
    while (acc_cnt == 3 && n < 50) begin tick(); n++; end
    a2 = acc_cyc;
    drv_valid = 0;
    wait_idle(100);
    check_val("b2b_period", a2 - a1, CH + LAT + 3);
    tick();

    // stray result while idle
    stray_req = 1;
    repeat (2) tick();
    send(rand_frame());
    wait_idle(100);
    tick();

    // reset in the middle of a frame; its late results must be ignored
    send(rand_frame());
    repeat (3) tick();
    do_reset(2);
    repeat (10) tick();
    send(rand_frame());
    wait_idle(100);

    // random backpressure and gaps
    tr_mode = 1;
    for (int f = 0; f < 25; f++) begin
      send(rand_frame());
      wait_idle(200);
      repeat ($urandom_range(0, 3)) tick();
    end
    tr_mode = 0;

`ifdef CORDIC_SCHED_TIMEOUT_EN
    // lost result triggers the watchdog
    drop_idx = 3;
    send(rand_frame());
    wait_idle(200);
    repeat (3) tick();
    check_val("timeout_sticky", timeout_out, 1'b1);
    // reset during DRAIN clears the flag
    send(rand_frame());
    n = 0;
    while (issued < CH && n < 50) begin tick(); n++; end
    tick();
    do_reset(2);
    drop_idx = -1;
    repeat (8) tick();
    send(rand_frame());
    wait_idle(100);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
